// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default parameters for the memory arbiter.
//   arb_state_t : arbitration state (OPEN fixed-priority / LOCKED aux burst).
//   owner_t     : which requester owns an in-flight read return.
//   *_DEF       : default ADDR_W / DATA_W / STARVE_MAX for mem_arbiter.
// DATA_W follows the global `REG_WIDTH define (8 if not provided).

`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 16;
  localparam int unsigned DATA_W_DEF     = `REG_WIDTH;
  localparam int unsigned STARVE_MAX_DEF = 8;
  localparam int unsigned STARVE_CNT_W   = 8;

  typedef enum logic {
    OPEN,
    LOCKED
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_AUX
  } owner_t;

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: bundle of the CPU, aux and memory-side signals of mem_arbiter.
//   slave  : view taken by the arbiter (requests/mem_rdata in, grants/bus out).
//   master : view taken by the surrounding requesters and memory.
// Ports: cpu_{req,we,addr,wdata,gnt,rvalid}, aux_{req,we,lock,addr,wdata,gnt,rvalid},
//        rdata, mem_{en,we,addr,wdata,rdata}.

interface mem_arb_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;

  logic              aux_req;
  logic              aux_we;
  logic              aux_lock;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata;
  logic              aux_gnt;
  logic              aux_rvalid;

  logic [DATA_W-1:0] rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid,
    input  aux_req, aux_we, aux_lock, aux_addr, aux_wdata,
    output aux_gnt, aux_rvalid,
    output rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid,
    output aux_req, aux_we, aux_lock, aux_addr, aux_wdata,
    input  aux_gnt, aux_rvalid,
    input  rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb_rdret.sv
// mem_arb_rdret: one-deep read-return pipeline of mem_arbiter.
//   clk, reset_n          : clock, synchronous active-low reset.
//   rd_owner              : requester granted a read this cycle (OWN_NONE otherwise).
//   mem_rdata             : memory read data, valid the cycle after the read grant.
//   cpu_rvalid/aux_rvalid : read return for that requester (grant + 1 cycle).
//   rdata                 : read data; memory data in the return cycle, held afterwards.

module mem_arb_rdret
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  owner_t            rd_owner,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_rvalid,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] rdata
);

  owner_t            owner_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ret_c;

  // A return is suppressed while reset is asserted, so a read granted just
  // before reset never surfaces.
  assign ret_c      = reset_n && (owner_q != OWN_NONE);
  assign cpu_rvalid = reset_n && (owner_q == OWN_CPU);
  assign aux_rvalid = reset_n && (owner_q == OWN_AUX);

  // Memory output is already registered; pass it through in the return
  // cycle and keep the captured copy until the next return.
  assign rdata = ret_c ? mem_rdata : rdata_q;

  // Return owner and captured read data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner_q <= OWN_NONE;
      rdata_q <= '0;
    end else begin
      owner_q <= rd_owner;
      if (ret_c) begin
        rdata_q <= mem_rdata;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU and an aux master
// (DMA / loader). Fixed priority CPU > aux, with an aux burst lock.
//   clk, reset_n : clock, synchronous active-low reset.
//   bus (slave)  : CPU/aux request and grant signals, shared rdata, memory port.
// Grants are combinational; read data returns one cycle after a read grant.
// Optional: `define MEM_ARB_STARVE_GUARD_EN forces an aux grant after
// STARVE_MAX consecutive CPU wins over a waiting aux request.

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input logic       clk,
  input logic       reset_n,
  mem_arb_if.slave  bus
);

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_starve_range
    $error("mem_arbiter: STARVE_MAX must be in 1..255");
  end

  arb_state_t        state;
  arb_state_t        state_nx;
  logic              cpu_gnt_c;
  logic              aux_gnt_c;
  logic              force_aux_c;
  owner_t            rd_owner_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [STARVE_CNT_W-1:0] starve_cnt;

  assign force_aux_c = (starve_cnt == STARVE_CNT_W'(STARVE_MAX));

  // Counts CPU wins over a waiting aux request; any aux grant or idle aux clears it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (aux_gnt_c || !bus.aux_req) begin
      starve_cnt <= '0;
    end else if (cpu_gnt_c && (state == OPEN)) begin
      starve_cnt <= starve_cnt + STARVE_CNT_W'(1);
    end
  end
`else
  assign force_aux_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= OPEN;
    end else begin
      state <= state_nx;
    end
  end

  // Grant decision and next state; nothing is granted while in reset.
  always_comb begin
    state_nx  = state;
    cpu_gnt_c = 1'b0;
    aux_gnt_c = 1'b0;
    if (reset_n) begin
      case (state)
        OPEN: begin
          if (bus.cpu_req && !(force_aux_c && bus.aux_req)) begin
            cpu_gnt_c = 1'b1;
          end else if (bus.aux_req) begin
            aux_gnt_c = 1'b1;
            if (bus.aux_lock) begin
              state_nx = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (bus.aux_req) begin
            aux_gnt_c = 1'b1;
            if (!bus.aux_lock) begin
              state_nx = OPEN;
            end
          end else begin
            // Aux let go of the bus: CPU may take this very cycle.
            cpu_gnt_c = bus.cpu_req;
            state_nx  = OPEN;
          end
        end
        default: state_nx = OPEN;
      endcase
    end
  end

  // Memory port mux from the granted requester; zero when idle.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    rd_owner_c  = OWN_NONE;
    if (cpu_gnt_c) begin
      mem_we_c    = bus.cpu_we;
      mem_addr_c  = bus.cpu_addr;
      mem_wdata_c = bus.cpu_wdata;
      if (!bus.cpu_we) begin
        rd_owner_c = OWN_CPU;
      end
    end else if (aux_gnt_c) begin
      mem_we_c    = bus.aux_we;
      mem_addr_c  = bus.aux_addr;
      mem_wdata_c = bus.aux_wdata;
      if (!bus.aux_we) begin
        rd_owner_c = OWN_AUX;
      end
    end
  end

  assign bus.cpu_gnt   = cpu_gnt_c;
  assign bus.aux_gnt   = aux_gnt_c;
  assign bus.mem_en    = cpu_gnt_c | aux_gnt_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;

  mem_arb_rdret #(
    .DATA_W (DATA_W)
  ) u_rdret (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_owner   (rd_owner_c),
    .mem_rdata  (bus.mem_rdata),
    .cpu_rvalid (bus.cpu_rvalid),
    .aux_rvalid (bus.aux_rvalid),
    .rdata      (bus.rdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// Directed vector table, a held-contention sequence (starvation guard when
// MEM_ARB_STARVE_GUARD_EN is defined, STARVE_MAX=3), then randomized
// requesters checked against a behavioural model with its own shadow memory.

module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned SMAX  = 3;
  localparam bit          GUARD = 1'b1;
`else
  localparam int unsigned SMAX  = STARVE_MAX_DEF;
  localparam bit          GUARD = 1'b0;
`endif
  localparam int RND_CYCLES = 3000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Power-up memory contents, identical for the memory and the model.
  function automatic logic [7:0] init_val(input logic [15:0] a);
    case (a)
      16'h0010: return 8'hA5;
      16'h0020: return 8'h3C;
      16'h0030: return 8'h5A;
      default:  return a[7:0] ^ a[15:8] ^ 8'h69;
    endcase
  endfunction

  // Synchronous memory: read data one cycle after a read strobe, noise otherwise.
  bit [7:0] mem    [0:65535];
  bit       mem_wr [0:65535];
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr]    <= bus.mem_wdata;
      mem_wr[bus.mem_addr] <= 1'b1;
    end
    if (bus.mem_en && !bus.mem_we)
      bus.mem_rdata <= mem_wr[bus.mem_addr] ? mem[bus.mem_addr] : init_val(bus.mem_addr);
    else
      bus.mem_rdata <= 8'($urandom);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic rst_n,
                       input logic c_req, input logic c_we, input logic [15:0] c_addr, input logic [7:0] c_wd,
                       input logic a_req, input logic a_we, input logic a_lock, input logic [15:0] a_addr,
                       input logic [7:0] a_wd);
    reset_n       = rst_n;
    bus.cpu_req   = c_req;
    bus.cpu_we    = c_we;
    bus.cpu_addr  = c_addr;
    bus.cpu_wdata = c_wd;
    bus.aux_req   = a_req;
    bus.aux_we    = a_we;
    bus.aux_lock  = a_lock;
    bus.aux_addr  = a_addr;
    bus.aux_wdata = a_wd;
  endtask

  typedef struct {
    logic        rst_n;
    logic        c_req, c_we;
    logic [15:0] c_addr;
    logic [7:0]  c_wd;
    logic        a_req, a_we, a_lock;
    logic [15:0] a_addr;
    logic [7:0]  a_wd;
    logic        e_cg, e_ag, e_cv, e_av, chk_rd;
    logic [7:0]  e_rd;
  } vec_t;

  function automatic vec_t mk(input logic rst_n,
                              input logic c_req, input logic c_we, input logic [15:0] c_addr, input logic [7:0] c_wd,
                              input logic a_req, input logic a_we, input logic a_lock, input logic [15:0] a_addr,
                              input logic [7:0] a_wd,
                              input logic e_cg, input logic e_ag, input logic e_cv, input logic e_av,
                              input logic chk_rd, input logic [7:0] e_rd);
    vec_t v;
    v.rst_n = rst_n;  v.c_req = c_req;   v.c_we = c_we;     v.c_addr = c_addr; v.c_wd = c_wd;
    v.a_req = a_req;  v.a_we = a_we;     v.a_lock = a_lock; v.a_addr = a_addr; v.a_wd = a_wd;
    v.e_cg = e_cg;    v.e_ag = e_ag;     v.e_cv = e_cv;     v.e_av = e_av;
    v.chk_rd = chk_rd; v.e_rd = e_rd;
    return v;
  endfunction

  vec_t vecs[$];

  // Reference model state (after the upcoming clock edge).
  bit          m_locked;
  int          m_cnt;
  int          m_ret;        // 0 none, 1 cpu, 2 aux
  logic [7:0]  m_ret_data;
  logic [7:0]  m_held;
  bit [7:0]    ref_mem [0:65535];
  bit          ref_wr  [0:65535];

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  initial begin
    vec_t       v;
    logic       e_c, e_a, e_cv, e_av;
    logic       c_seen, a_seen;
    logic [7:0] e_rd;
    logic [25:0] e_bus;

    drive(1'b0, 0, 0, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0);
    repeat (2) @(posedge clk);

    //          rst c_req we addr      wd     a_req we lk addr      wd     cg ag cv av chk rd
    vecs.push_back(mk(0, 1, 0, 16'h0010, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 1, 8'h00));
    vecs.push_back(mk(1, 1, 0, 16'h0010, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 1, 8'h00));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0, 0, 1, 0, 1, 8'hA5));
    vecs.push_back(mk(1, 1, 0, 16'h0020, 8'h00, 1, 0, 0, 16'h0030, 8'h00, 1, 0, 0, 0, 1, 8'hA5));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 16'h0030, 8'h00, 0, 1, 1, 0, 1, 8'h3C));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 1, 1, 8'h5A));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 1, 1, 1, 16'h0200, 8'h01, 0, 1, 0, 0, 1, 8'h5A));
    vecs.push_back(mk(1, 1, 0, 16'h0010, 8'h00, 1, 1, 1, 16'h0201, 8'h02, 0, 1, 0, 0, 1, 8'h5A));
    vecs.push_back(mk(1, 1, 0, 16'h0010, 8'h00, 1, 1, 1, 16'h0202, 8'h03, 0, 1, 0, 0, 1, 8'h5A));
    vecs.push_back(mk(1, 1, 0, 16'h0010, 8'h00, 1, 1, 0, 16'h0203, 8'h04, 0, 1, 0, 0, 1, 8'h5A));
    vecs.push_back(mk(1, 1, 0, 16'h0010, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 1, 8'h5A));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0, 0, 1, 0, 1, 8'hA5));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 1, 8'hA5));
    vecs.push_back(mk(1, 1, 0, 16'h0020, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 1, 8'hA5));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 16'h0030, 8'h00, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 1, 8'h00));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 1, 1, 1, 16'h0204, 8'h05, 0, 1, 0, 0, 1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 1, 1, 1, 16'h0205, 8'h06, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 16'h0202, 8'h00, 1, 1, 1, 16'h0205, 8'h06, 1, 0, 0, 0, 1, 8'h00));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 1, 1, 1, 16'h0205, 8'h06, 0, 1, 1, 0, 1, 8'h03));
    vecs.push_back(mk(1, 1, 0, 16'h0201, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 1, 8'h03));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 16'h0203, 8'h00, 0, 1, 1, 0, 1, 8'h02));
    vecs.push_back(mk(1, 1, 1, 16'h0300, 8'h77, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 1, 1, 8'h04));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 1, 8'h04));
    vecs.push_back(mk(1, 1, 0, 16'h0300, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 1, 8'h04));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0, 0, 1, 0, 1, 8'h77));

    // Directed table.
    foreach (vecs[i]) begin
      v = vecs[i];
      @(posedge clk); #1;
      drive(v.rst_n, v.c_req, v.c_we, v.c_addr, v.c_wd, v.a_req, v.a_we, v.a_lock, v.a_addr, v.a_wd);
      @(negedge clk);
      e_bus = v.e_cg ? {1'b1, v.c_we, v.c_addr, v.c_wd} :
              v.e_ag ? {1'b1, v.a_we, v.a_addr, v.a_wd} : 26'h0;
      check($sformatf("vec%0d gnt", i), {bus.cpu_gnt, bus.aux_gnt}, {v.e_cg, v.e_ag});
      check($sformatf("vec%0d membus", i), {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, e_bus);
      check($sformatf("vec%0d rvalid", i), {bus.cpu_rvalid, bus.aux_rvalid}, {v.e_cv, v.e_av});
      if (v.chk_rd) check($sformatf("vec%0d rdata", i), bus.rdata, v.e_rd);
    end

    // Held contention: CPU always wins unless the starvation guard is built in.
    @(posedge clk); #1;
    drive(1'b1, 0, 0, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      drive(1'b1, 1, 0, 16'h0010, 8'h00, 1, 0, 0, 16'h0030, 8'h00);
      @(negedge clk);
      e_a = GUARD && ((k % 4) == 3);
      check($sformatf("starve%0d gnt", k), {bus.cpu_gnt, bus.aux_gnt}, {~e_a, e_a});
    end

    // Randomized requesters against the behavioural model.
    m_locked = 0; m_cnt = 0; m_ret = 0; m_ret_data = 8'h0; m_held = 8'h0;
    c_seen = 0; a_seen = 0;
    drive(1'b1, 0, 0, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0);
    for (int i = 0; i < RND_CYCLES; i++) begin
      @(posedge clk); #1;
      reset_n = (i == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      if (!bus.cpu_req || c_seen) begin
        bus.cpu_req   = ($urandom_range(0, 99) < 55);
        bus.cpu_we    = ($urandom_range(0, 2) == 0);
        bus.cpu_addr  = 16'h1000 | 16'($urandom_range(0, 255));
        bus.cpu_wdata = 8'($urandom);
      end else if ($urandom_range(0, 99) < 5) begin
        bus.cpu_req = 1'b0;
      end
      if (!bus.aux_req || a_seen) begin
        bus.aux_req   = ($urandom_range(0, 99) < 45);
        bus.aux_we    = ($urandom_range(0, 1) == 0);
        bus.aux_lock  = ($urandom_range(0, 99) < 60);
        bus.aux_addr  = 16'h1000 | 16'($urandom_range(0, 255));
        bus.aux_wdata = 8'($urandom);
      end else if ($urandom_range(0, 99) < 5) begin
        bus.aux_req = 1'b0;
      end

      @(negedge clk);
      e_c = 0; e_a = 0;
      if (reset_n) begin
        if (m_locked && bus.aux_req) e_a = 1;
        else if (bus.cpu_req && !(GUARD && (m_cnt == int'(SMAX)) && bus.aux_req)) e_c = 1;
        else if (bus.aux_req) e_a = 1;
      end
      e_cv  = reset_n && (m_ret == 1);
      e_av  = reset_n && (m_ret == 2);
      e_rd  = (e_cv || e_av) ? m_ret_data : m_held;
      e_bus = e_c ? {1'b1, bus.cpu_we, bus.cpu_addr, bus.cpu_wdata} :
              e_a ? {1'b1, bus.aux_we, bus.aux_addr, bus.aux_wdata} : 26'h0;
      check($sformatf("rnd%0d gnt", i), {bus.cpu_gnt, bus.aux_gnt}, {e_c, e_a});
      check($sformatf("rnd%0d membus", i), {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, e_bus);
      check($sformatf("rnd%0d rvalid", i), {bus.cpu_rvalid, bus.aux_rvalid}, {e_cv, e_av});
      if (reset_n) check($sformatf("rnd%0d rdata", i), bus.rdata, e_rd);
      c_seen = bus.cpu_gnt;
      a_seen = bus.aux_gnt;

      // Advance the model across the clock edge.
      if (!reset_n) begin
        m_locked = 0; m_cnt = 0; m_ret = 0; m_held = 8'h0;
      end else begin
        if (m_ret != 0) m_held = m_ret_data;
        m_ret = 0;
        if (e_c && !bus.cpu_we) begin m_ret = 1; m_ret_data = ref_read(bus.cpu_addr); end
        if (e_a && !bus.aux_we) begin m_ret = 2; m_ret_data = ref_read(bus.aux_addr); end
        if (e_c && bus.cpu_we) begin ref_mem[bus.cpu_addr] = bus.cpu_wdata; ref_wr[bus.cpu_addr] = 1'b1; end
        if (e_a && bus.aux_we) begin ref_mem[bus.aux_addr] = bus.aux_wdata; ref_wr[bus.aux_addr] = 1'b1; end
        if (e_a) m_locked = bus.aux_lock;
        else if (!bus.aux_req) m_locked = 0;
        if (e_a || !bus.aux_req) m_cnt = 0;
        else if (e_c) m_cnt++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
